// File: rtl/password_lock_pkg.sv
// Shared types and segment constants for the password lock.
// Segments are active-low, bit 6 = g ... bit 0 = a.
package password_lock_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PROG,
      VERIFY,
      CHECK,
      OPEN,
      FAIL,
      LOCKOUT
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;

endpackage

// File: rtl/password_lock_if.sv
// Keypad/status bundle of the password lock.
// master = keypad side, slave = lock side.
interface password_lock_if #(
   parameter int DIGITS  = 4,
   parameter int DIGIT_W = 4
);

   logic                         confirm;
   logic                         mode;
   logic [DIGIT_W-1:0]           input_data;
   logic                         admitted;
   logic                         denied;
   logic                         locked;
   logic [$clog2(DIGITS+1)-1:0]  digit_idx;
   logic [7*DIGITS-1:0]          display;

   modport master (
      output confirm, mode, input_data,
      input  admitted, denied, locked,
      input  digit_idx, display
   );

   modport slave (
      input  confirm, mode, input_data,
      output admitted, denied, locked,
      output digit_idx, display
   );

endinterface

// File: rtl/password_lock_seg7_decode.sv
// One digit to active-low 7-segment pattern.
// Values above 9 show as 'E'.
module seg7_decode
   import password_lock_pkg::*;
#(
   parameter int DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   logic [31:0] val;

   assign val = 32'(digit);

   always_comb begin
      seg = SEG_E;
      case (val)
         32'd0:   seg = 7'b1000000;
         32'd1:   seg = 7'b1111001;
         32'd2:   seg = 7'b0100100;
         32'd3:   seg = 7'b0110000;
         32'd4:   seg = 7'b0011001;
         32'd5:   seg = 7'b0010010;
         32'd6:   seg = 7'b0000010;
         32'd7:   seg = 7'b1111000;
         32'd8:   seg = 7'b0000000;
         32'd9:   seg = 7'b0010000;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/password_lock.sv
// Digit-code lock: program, verify, lockout after repeated failures.
// Define PASSWORD_LOCK_MASK_EN to show dashes for digits being verified.
module password_lock
   import password_lock_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DIGIT_W     = 4,
   parameter int MAX_TRIES   = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        confirm,
   input  logic                        mode,
   input  logic [DIGIT_W-1:0]          input_data,
   output logic                        admitted,
   output logic                        denied,
   output logic                        locked,
   output logic [$clog2(DIGITS+1)-1:0] digit_idx,
   output logic [7*DIGITS-1:0]         display
);

   localparam int IW = $clog2(DIGITS+1);
   localparam int FW = $clog2(MAX_TRIES+1);
   localparam int TW = $clog2(LOCK_CYCLES+1);

`ifdef PASSWORD_LOCK_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   state_t             state;
   logic               conf_q;
   logic               pw_set;
   logic [DIGIT_W-1:0] target [DIGITS];
   logic [DIGIT_W-1:0] entry  [DIGITS];
   logic [FW-1:0]      fail_cnt;
   logic [FW-1:0]      fail_nx;
   logic [TW-1:0]      timer;
   logic               press;
   logic               last;
   logic               match;

   assign press   = conf_q & ~confirm;
   assign last    = digit_idx == IW'(DIGITS-1);
   assign fail_nx = fail_cnt + 1'b1;

   always_comb begin
      match = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (entry[i] != target[i])
            match = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         conf_q    <= 1'b1;
         pw_set    <= 1'b0;
         fail_cnt  <= '0;
         timer     <= '0;
         admitted  <= 1'b0;
         denied    <= 1'b0;
         locked    <= 1'b0;
         digit_idx <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            target[i] <= '0;
            entry[i]  <= '0;
         end
      end else begin
         conf_q <= confirm;
         denied <= 1'b0;
         case (state)
            IDLE: if (press) begin
               state     <= pw_set ? VERIFY : PROG;
               digit_idx <= '0;
               for (int i = 0; i < DIGITS; i++)
                  entry[i] <= '0;
            end
            PROG: if (press) begin
               for (int i = 0; i < DIGITS; i++)
                  if (digit_idx == IW'(i)) begin
                     target[i] <= input_data;
                     entry[i]  <= input_data;
                  end
               if (last) begin
                  pw_set    <= 1'b1;
                  digit_idx <= '0;
                  state     <= IDLE;
               end else begin
                  digit_idx <= digit_idx + 1'b1;
               end
            end
            VERIFY: if (press) begin
               for (int i = 0; i < DIGITS; i++)
                  if (digit_idx == IW'(i))
                     entry[i] <= input_data;
               digit_idx <= digit_idx + 1'b1;
               if (last)
                  state <= CHECK;
            end
            CHECK: begin
               if (match) begin
                  state    <= OPEN;
                  admitted <= 1'b1;
                  fail_cnt <= '0;
               end else begin
                  // wrong code: hide it at once
                  digit_idx <= '0;
                  fail_cnt  <= fail_nx;
                  for (int i = 0; i < DIGITS; i++)
                     entry[i] <= '0;
                  if (fail_nx == FW'(MAX_TRIES)) begin
                     state  <= LOCKOUT;
                     locked <= 1'b1;
                     timer  <= TW'(LOCK_CYCLES);
                  end else begin
                     state  <= FAIL;
                     denied <= 1'b1;
                  end
               end
            end
            FAIL: begin
               state     <= IDLE;
               digit_idx <= '0;
               for (int i = 0; i < DIGITS; i++)
                  entry[i] <= '0;
            end
            OPEN: if (press) begin
               state     <= mode ? PROG : IDLE;
               admitted  <= 1'b0;
               digit_idx <= '0;
               for (int i = 0; i < DIGITS; i++)
                  entry[i] <= '0;
            end
            LOCKOUT: begin
               timer <= timer - 1'b1;
               if (timer == TW'(1)) begin
                  state    <= IDLE;
                  locked   <= 1'b0;
                  fail_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      logic [6:0] dec;
      logic       show;
      logic       hide;

      seg7_decode #(.DIGIT_W(DIGIT_W)) u_dec (
         .digit (entry[g]),
         .seg   (dec)
      );

      assign show = (IW'(g) < digit_idx) ||
                    (state == OPEN) || (state == CHECK);
      assign hide = MASK &&
                    ((state == VERIFY) || (state == CHECK));
      assign display[7*g +: 7] = !show ? SEG_BLANK :
                                 hide  ? SEG_DASH  : dec;
   end

endmodule

// File: doc/password_lock.md
PASSWORD_LOCK -- requirements
Module: password_lock

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DIGITS       4   password length in digits (legal 1..8)
  DIGIT_W      4   bits per digit (BCD when 4)
  MAX_TRIES    3   consecutive wrong entries before lockout (>=1)
  LOCK_CYCLES  16  lockout duration in clk cycles (>=1)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk          in   1                clock, all state on rising edge
  rst          in   1                asynchronous active-low reset
  confirm      in   1                active-low push button, synchronous to clk
  mode         in   1                1 = program request, 0 = verify/relock
  input_data   in   DIGIT_W          digit captured on each press
  admitted     out  1                level, high while OPEN
  denied       out  1                one-cycle pulse on wrong entry
  locked       out  1                level, high while LOCKOUT
  digit_idx    out  clog2(DIGITS+1)  digits entered so far
  display      out  7*DIGITS         active-low segments, digit 0 in [6:0]
REQ-003 One clock, clk; reset is asynchronous and active-low on rst.

Function
REQ-004 A press SHALL be a 1->0 transition of confirm, sampled against a registered copy (reset value 1); exactly one action per press regardless of hold time.
REQ-005 FSM states SHALL be IDLE, PROG, VERIFY, CHECK, OPEN, FAIL, LOCKOUT.
REQ-006 IDLE: press -> PROG if no password stored, else VERIFY; entry buffer blanked, digit_idx=0; no digit captured on this press.
REQ-007 PROG: each press writes input_data to target[digit_idx] and entry[digit_idx], digit_idx+1; DIGITS-th press sets pw_set=1, goes to IDLE.
REQ-008 VERIFY: each press writes entry[digit_idx], digit_idx+1; DIGITS-th press goes to CHECK next cycle.
REQ-009 CHECK (exactly one cycle): all DIGITS compared; match -> OPEN, fail_cnt=0; mismatch with fail_cnt+1==MAX_TRIES -> LOCKOUT, lock timer=LOCK_CYCLES; otherwise fail_cnt+1 -> FAIL.
REQ-010 FAIL (one cycle): denied=1, entry blanked, then IDLE.
REQ-011 OPEN: admitted=1; press with mode=1 -> PROG (reprogram); press with mode=0 -> IDLE; admitted falls on the cycle after the press.
REQ-012 LOCKOUT: locked=1; timer decrements each cycle; presses ignored; timer reaching 0 -> IDLE with fail_cnt=0; total locked time exactly LOCK_CYCLES cycles.
REQ-013 Presses in CHECK and FAIL SHALL be discarded, not queued; mode changes mid-entry have no effect.
REQ-014 display digit i SHALL show entry[i] decoded (0-9; values >9 shown as 'E') when i<digit_idx or state is OPEN/CHECK, else blank (all 1).
REQ-015 Counters SHALL be sized clog2(MAX_TRIES+1) and clog2(LOCK_CYCLES+1) bits; no wrap possible at legal parameters.

Reset
REQ-016 rst low SHALL immediately force IDLE, pw_set=0, target and entry all zero, fail_cnt=0, timer=0, confirm copy=1, admitted=denied=locked=0, digit_idx=0, display blank; applies mid-entry and mid-lockout.

Configuration
REQ-017 Macro PASSWORD_LOCK_MASK_EN: when defined, digits entered in VERIFY and shown in CHECK display as a dash (only segment g lit); PROG and OPEN unaffected. When undefined, all entered digits show their value.

Structure
REQ-018 Package password_lock_pkg SHALL hold the state enum, SEG_BLANK, SEG_DASH and SEG_E constants.
REQ-019 One sub-module, seg7_decode (DIGIT_W in, 7 active-low out), instantiated DIGITS times via generate.

Verification (DIGITS=4, MAX_TRIES=3, LOCK_CYCLES=16)
REQ-020 Reset, press, program 1-2-3-4 -> IDLE, pw_set=1; press, enter 1-2-3-4 -> admitted=1 two cycles after the 4th press.
REQ-021 Stored 1234, enter 1-2-3-5 -> one-cycle denied pulse, admitted=0, display blanks.
REQ-022 Three wrong entries -> locked=1 for exactly 16 cycles, presses during lockout ignored, then IDLE and a correct entry admits.
REQ-023 In OPEN, mode=1, press, program 9-8-7-6 -> old code 1234 denied, 9876 admitted.
REQ-024 confirm held low 50 cycles -> one digit captured; rst pulsed after 2 digits in VERIFY -> all outputs at reset values, next press enters PROG.
REQ-025 With PASSWORD_LOCK_MASK_EN defined, VERIFY digits show 7'b0111111; undefined, show decoded values.
